// File: rtl/mips_pkg.sv
// mips_pkg: instruction classes, opcodes and field positions shared by the encoder and main-control decoder.
package mips_pkg;
    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_ADDI = 3'd4
    } instr_class_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    // Illegal classes map to OP_R; callers gate them out before use.
    function automatic logic [5:0] class_opcode(input logic [2:0] c);
        return (c == CLS_LW)   ? OP_LW :
               (c == CLS_SW)   ? OP_SW :
               (c == CLS_BEQ)  ? OP_BEQ :
               (c == CLS_ADDI) ? OP_ADDI : OP_R;
    endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-tuple input handshake, flush control and imem write port of the encoder.
interface instr_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic              flush;
    logic              imem_stall;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              err_illegal;
    logic [15:0]       word_count;

    modport master (
        output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, flush, imem_stall,
        input  in_ready, imem_we, imem_addr, imem_wdata, done, err_illegal, word_count
    );
    modport slave (
        input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, flush, imem_stall,
        output in_ready, imem_we, imem_addr, imem_wdata, done, err_illegal, word_count
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS field tuples, buffers them and streams them into imem at consecutive word addresses.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0
) (
    input logic            clk,
    input logic            rst,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    state_t            state;
    logic [31:0]       enc_word;
    logic [31:0]       head;
    logic [5:0]        op;
    logic [ADDR_W-1:0] next_addr;
    logic              full, empty, legal, accept, pop, retire, drain_ok;
    always_comb begin
        op       = class_opcode(bus.in_class);
        enc_word = (bus.in_class == CLS_R) ? {op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct}
                                           : {op, bus.in_rs, bus.in_rt, bus.in_imm};
    end
    assign legal        = bus.in_class <= CLS_ADDI;
    assign bus.in_ready = (state == RUN) && !full && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = !bus.imem_stall && !empty;
    assign retire       = bus.imem_we && !bus.imem_stall;
    // Flush completes only once the last presented write is actually taken by imem.
    assign drain_ok     = empty && (!bus.imem_we || !bus.imem_stall);
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && legal),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.imem_we     <= 1'b0;
            bus.imem_addr   <= BASE;
            bus.imem_wdata  <= '0;
            bus.err_illegal <= 1'b0;
            bus.word_count  <= '0;
            next_addr       <= BASE;
        end else begin
            if (!bus.imem_stall) bus.imem_we <= !empty;
            if (pop) begin
                bus.imem_wdata <= head;
                bus.imem_addr  <= next_addr;
                next_addr      <= next_addr + ADDR_W'(4);
            end
            if (accept && !legal) bus.err_illegal <= 1'b1;
            if (retire && bus.word_count != 16'hFFFF) bus.word_count <= bus.word_count + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            bus.done <= 1'b0;
        end else begin
            state    <= (state == RUN)   ? (bus.flush ? FLUSH : RUN) :
                        (state == FLUSH) ? (drain_ok ? DONE : FLUSH) : RUN;
            bus.done <= (state == FLUSH) && drain_ok;
        end
    end
endmodule
